mul_ctrl: RTL and testbench
===========================

Name: mul_ctrl

Overview:
- Sequencing controller between the execute stage and the iterative 64x64->128 multiplier core (mALU).
- Decodes RV64M multiply ops and drives the core's operands, signedness and start/ready protocol.
- Corrects the MULHSU sign, selects the result half, and returns results over a valid/ready response port.
- Holds a one-entry product cache, so a MULH/MUL pair on the same operands costs one multiply.

Parameters:
- TAG_W, 5, width of the request/response tag (destination register id).
- CACHE_EN, 1, enables the one-entry product cache (0 = every request runs the core).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  pipeline flush: abort in-flight op, drop pending response
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, others illegal
- req_word  in  1  W-form (MULW); legal only with req_op=000
- req_rs1  in  64  operand 1
- req_rs2  in  64  operand 2
- req_tag  in  TAG_W  opaque tag, returned with the result
- resp_valid  out  1  result present
- resp_ready  in  1  consumer accepts result
- resp_data  out  64  result
- resp_tag  out  TAG_W  tag of the result
- mul_a  out  64  core operand A
- mul_b  out  64  core operand B
- mul_signed_a  out  1  core signedness A
- mul_signed_b  out  1  core signedness B
- mul_start  out  1  core start, level
- mul_result  in  128  core product
- mul_ready  in  1  core done, one-cycle pulse
- busy  out  1  state != IDLE

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset forces state IDLE, cache invalid, and all outputs 0 (req_ready=1 once out of reset).
- Core contract:
  - mul_start must be held high until mul_ready.
  - Dropping mul_start mid-run aborts the core.
  - mul_start must be low for at least 1 cycle between ops.
  - The core sign-corrects only when both signed flags are high.
- States: IDLE, RUN, RESP.
- IDLE:
  - req_ready = !flush.
  - Accept on req_valid & req_ready; latch op, word, operands, tag.
  - Illegal op, or word with op != 000: go to RESP with resp_data = 0; the core is not started.
  - Cache hit: go to RESP with the cached product selected.
  - Otherwise: go to RUN.
- Operand mapping (registered at accept):
  - MUL: a=rs1, b=rs2, signed 0/0.
  - MULW: a=zext(rs1[31:0]), b=zext(rs2[31:0]), signed 0/0.
  - MULH: a=rs1, b=rs2, signed 1/1.
  - MULHU: a=rs1, b=rs2, signed 0/0.
  - MULHSU: a=|rs1| (two's-complement magnitude), b=rs2, signed 0/0; neg flag = rs1[63].
- RUN:
  - mul_start = 1 from the cycle after accept.
  - On mul_ready: capture P = neg ? -mul_result (128-bit two's complement) : mul_result. Drop mul_start the same cycle (combinational from state). Go to RESP.
- Result select:
  - MUL: P[63:0].
  - MULW: sext(P[31:0]).
  - MULH/MULHSU/MULHU: P[127:64].
- RESP:
  - resp_valid = 1; resp_data and resp_tag stable until resp_valid & resp_ready.
  - On handshake: go to IDLE.
- Latency:
  - Miss: resp_valid rises 1 cycle after mul_ready.
  - Hit or illegal: resp_valid rises the cycle after accept.
- Cache (CACHE_EN=1):
  - Stores rs1, rs2, signedness class (SS/SU/UU) and the 128-bit P of the last completed non-W op.
  - Hit when rs1 and rs2 match and either the class matches, or the new op is MUL (low half is class-independent).
  - MULW never hits and never fills.
- Flush:
  - RUN: mul_start drops that cycle, go to IDLE, no response, cache unchanged.
  - RESP: response dropped, go to IDLE.
  - IDLE: no accept that cycle.
- Simultaneous mul_ready & flush: flush wins; the result is discarded and not cached.
- Reset mid-RUN: mul_start low immediately (asynchronous).

Decomposition:
- Shared package mul_pkg:
  - enum mul_op_e (funct3 encodings).
  - enum mul_class_e (SS/SU/UU).
  - state enum.
  - function sel_result(op, word, P).
- Sub-module mul_result_cache: compare/fill logic and storage for the one-entry cache.

Test Plan:
- MULH rs1=0xFFFF_FFFF_FFFF_FFFE (-2), rs2=3 -> resp_data=0xFFFF_FFFF_FFFF_FFFF. mul_start held until mul_ready; resp_valid 1 cycle after mul_ready.
- MULHSU rs1=-1, rs2=0xFFFF_FFFF_FFFF_FFFF -> resp_data=0xFFFF_FFFF_FFFF_FFFF (P=-(2^64-1)); core driven with signed 0/0 and a=1.
- MULHU 2^63 x 4 -> resp_data=2; then MUL with the same operands -> cache hit, resp_data=0, resp_valid the cycle after accept, mul_start never asserted.
- MULW rs1=0x0000_0000_8000_0000, rs2=1 -> resp_data=0xFFFF_FFFF_8000_0000; req_word with op=001 -> resp_data=0, core not started.
- Flush 5 cycles into RUN -> mul_start low that cycle, no resp_valid. Next MUL 7x6 -> 42, with mul_start low for at least 1 cycle between ops.
- resp_ready held low 10 cycles -> resp_data/resp_tag stable, req_ready=0; back-to-back requests show a gap of at least 1 mul_start-low cycle.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and helpers for the RV64M multiply sequencing controller.
// Op encodings follow funct3; class captures the operand signedness of a product.
package mul_pkg;

  localparam int XLEN   = 64;
  localparam int PROD_W = 2 * XLEN;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011
  } mul_op_e;

  typedef enum logic [1:0] {
    CLS_UU = 2'd0,
    CLS_SU = 2'd1,
    CLS_SS = 2'd2
  } mul_class_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // funct3 values 1xx are illegal; the W form exists only for MUL.
  function automatic logic op_legal(input logic [2:0] op, input logic word);
    return (op[2] == 1'b0) && (!word || op == OP_MUL);
  endfunction

  // MUL runs the core unsigned, so its full product belongs to the UU class.
  function automatic mul_class_e op_class(input logic [2:0] op);
    mul_class_e cls;
    case (op)
      OP_MULH:   cls = CLS_SS;
      OP_MULHSU: cls = CLS_SU;
      default:   cls = CLS_UU;
    endcase
    return cls;
  endfunction

  function automatic logic [XLEN-1:0] sel_result(input logic [2:0]        op,
                                                 input logic              word,
                                                 input logic [PROD_W-1:0] p);
    logic [XLEN-1:0] res;
    if (word) begin
      res = {{32{p[31]}}, p[31:0]};
    end else if (op == OP_MUL) begin
      res = p[XLEN-1:0];
    end else begin
      res = p[PROD_W-1:XLEN];
    end
    return res;
  endfunction

endpackage

// File: rtl/mul_result_cache.sv
// One-entry cache of the last full product computed by the core, keyed on
// both operands and the signedness class it was computed with.
module mul_result_cache
  import mul_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_en,
  input  logic [XLEN-1:0]   lookup_rs1,
  input  logic [XLEN-1:0]   lookup_rs2,
  input  mul_class_e        lookup_cls,
  input  logic              lookup_any_cls,
  output logic              hit,
  output logic [PROD_W-1:0] hit_p,
  input  logic              fill,
  input  logic [XLEN-1:0]   fill_rs1,
  input  logic [XLEN-1:0]   fill_rs2,
  input  mul_class_e        fill_cls,
  input  logic [PROD_W-1:0] fill_p
);

  logic              valid;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   rs2_q;
  mul_class_e        cls_q;
  logic [PROD_W-1:0] p_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (fill && EN) begin
      valid <= 1'b1;
    end
  end

  // NOTE: payload storage has no reset; valid alone decides whether it means anything.
  always_ff @(posedge clk) begin
    if (fill && EN) begin
      rs1_q <= fill_rs1;
      rs2_q <= fill_rs2;
      cls_q <= fill_cls;
      p_q   <= fill_p;
    end
  end

  // The low half is identical for every class, so MUL may reuse any entry.
  assign hit = EN && valid && lookup_en &&
               (lookup_rs1 == rs1_q) && (lookup_rs2 == rs2_q) &&
               (lookup_any_cls || lookup_cls == cls_q);

  assign hit_p = p_q;

endmodule

// File: rtl/mul_ctrl.sv
// Sequencer between execute and the iterative 64x64->128 multiplier core:
// decode, operand conditioning, start/ready protocol, result select and response.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int TAG_W    = 5,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic              req_word,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic [XLEN-1:0]   mul_a,
  output logic [XLEN-1:0]   mul_b,
  output logic              mul_signed_a,
  output logic              mul_signed_b,
  output logic              mul_start,
  input  logic [PROD_W-1:0] mul_result,
  input  logic              mul_ready,
  output logic              busy
);

  state_e            state;
  state_e            state_nxt;

  logic [2:0]        op_q;
  logic              word_q;
  logic              neg_q;
  logic [TAG_W-1:0]  tag_q;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   rs2_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic              sa_q;
  logic              sb_q;
  logic [XLEN-1:0]   data_q;

  logic              accept;
  logic              legal;
  logic              hit;
  logic              done;
  logic [PROD_W-1:0] hit_p;
  logic [PROD_W-1:0] prod;
  logic [XLEN-1:0]   a_nxt;
  logic [XLEN-1:0]   b_nxt;

  assign legal  = op_legal(req_op, req_word);
  assign accept = (state == ST_IDLE) && req_valid && !flush;
  // A flush in the same cycle as mul_ready discards the product entirely.
  assign done   = (state == ST_RUN) && mul_ready && !flush;
  assign prod   = neg_q ? -mul_result : mul_result;

  mul_result_cache #(
    .EN (CACHE_EN)
  ) u_cache (
    .clk            (clk),
    .rst            (rst),
    .lookup_en      (legal && !req_word),
    .lookup_rs1     (req_rs1),
    .lookup_rs2     (req_rs2),
    .lookup_cls     (op_class(req_op)),
    .lookup_any_cls (req_op == OP_MUL),
    .hit            (hit),
    .hit_p          (hit_p),
    .fill           (done && !word_q),
    .fill_rs1       (rs1_q),
    .fill_rs2       (rs2_q),
    .fill_cls       (op_class(op_q)),
    .fill_p         (prod)
  );

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    a_nxt = req_rs1;
    b_nxt = req_rs2;
    if (req_word) begin
      a_nxt = {32'b0, req_rs1[31:0]};
      b_nxt = {32'b0, req_rs2[31:0]};
    end else if (req_op == OP_MULHSU && req_rs1[XLEN-1]) begin
      // The core only sign-corrects SS, so SU runs as UU on |rs1| and is negated afterwards.
      a_nxt = -req_rs1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (!legal || hit) ? ST_RESP : ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (mul_ready) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (flush || resp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      word_q <= 1'b0;
      neg_q  <= 1'b0;
      tag_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      data_q <= '0;
    end else begin
      if (accept) begin
        op_q   <= req_op;
        word_q <= req_word;
        neg_q  <= (req_op == OP_MULHSU) && !req_word && req_rs1[XLEN-1];
        tag_q  <= req_tag;
        rs1_q  <= req_rs1;
        rs2_q  <= req_rs2;
        a_q    <= a_nxt;
        b_q    <= b_nxt;
        sa_q   <= (req_op == OP_MULH);
        sb_q   <= (req_op == OP_MULH);
        // Illegal ops answer zero; a hit answers from the cache; a miss is overwritten on done.
        data_q <= legal ? sel_result(req_op, req_word, hit_p) : '0;
      end
      if (done) begin
        data_q <= sel_result(op_q, word_q, prod);
      end
    end
  end

  // Start is decoded from state so the asynchronous reset removes it immediately.
  assign mul_start    = (state == ST_RUN) && !flush;
  assign req_ready    = (state == ST_IDLE) && !flush && !rst;
  assign resp_valid   = (state == ST_RESP);
  assign resp_data    = data_q;
  assign resp_tag     = tag_q;
  assign busy         = (state != ST_IDLE);
  assign mul_a        = a_q;
  assign mul_b        = b_q;
  assign mul_signed_a = sa_q;
  assign mul_signed_b = sb_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: behavioural multiplier core, directed table, hand-written
// flush/reset sequences and randomized requests against an arithmetic reference.
`timescale 1ns/1ps
module tb_mul_ctrl;

  localparam int TAG_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [2:0]        req_op = '0;
  logic              req_word = 1'b0;
  logic [63:0]       req_rs1 = '0;
  logic [63:0]       req_rs2 = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [63:0]       resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic [63:0]       mul_a;
  logic [63:0]       mul_b;
  logic              mul_signed_a;
  logic              mul_signed_b;
  logic              mul_start;
  logic [127:0]      mul_result = '0;
  logic              mul_ready = 1'b0;
  logic              busy;

  always #5 clk = ~clk;

  mul_ctrl #(.TAG_W(TAG_W), .CACHE_EN(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_word     (req_word),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_tag      (req_tag),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_tag     (resp_tag),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_signed_a (mul_signed_a),
    .mul_signed_b (mul_signed_b),
    .mul_start    (mul_start),
    .mul_result   (mul_result),
    .mul_ready    (mul_ready),
    .busy         (busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural multiplier core ----------------
  int   force_lat = 0;
  int   core_lat = 1;
  int   core_cnt = 0;
  bit   core_run = 0;
  bit   post_ready = 0;
  bit   prev_start = 0;
  int   starts = 0;
  int   aborts = 0;
  int   gap_viol = 0;
  int   ready_cyc = 0;
  logic [63:0] seen_a = '0;
  logic [63:0] seen_b = '0;
  logic seen_sa = 1'b0;
  logic seen_sb = 1'b0;

  function automatic logic [127:0] core_product(input logic [63:0] a, input logic [63:0] b,
                                                input logic sa, input logic sb);
    logic [127:0] xa;
    logic [127:0] xb;
    xa = {64'b0, a};
    xb = {64'b0, b};
    if (sa && sb) begin
      xa = {{64{a[63]}}, a};
      xb = {{64{b[63]}}, b};
    end
    return xa * xb;
  endfunction

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      mul_ready  = 1'b0;
      core_run   = 0;
      post_ready = 0;
      prev_start = 0;
    end else begin
      if (mul_ready) begin
        mul_ready  = 1'b0;
        post_ready = 1;
      end
      if (!mul_start) begin
        post_ready = 0;
      end else if (post_ready) begin
        gap_viol++;
        post_ready = 0;
      end else if (!prev_start) begin
        starts++;
        core_run = 1;
        core_cnt = 0;
        core_lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 6));
        seen_a   = mul_a;
        seen_b   = mul_b;
        seen_sa  = mul_signed_a;
        seen_sb  = mul_signed_b;
      end
      if (core_run && !mul_start) begin
        aborts++;
        core_run = 0;
      end
      if (core_run) begin
        core_cnt++;
        if (core_cnt >= core_lat) begin
          mul_ready  = 1'b1;
          mul_result = core_product(mul_a, mul_b, mul_signed_a, mul_signed_b);
          core_run   = 0;
          ready_cyc  = cyc;
        end
      end
      prev_start = mul_start;
    end
  end

  // ---------------- reference model ----------------
  bit          cm_valid = 0;
  logic [63:0] cm_rs1 = '0;
  logic [63:0] cm_rs2 = '0;
  int          cm_cls = 0;

  function automatic bit ref_legal(input logic [2:0] op, input logic word);
    return (op < 3'd4) && (!word || op == 3'd0);
  endfunction

  function automatic int ref_cls(input logic [2:0] op);
    return (op == 3'd1) ? 2 : (op == 3'd2) ? 1 : 0;
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic word,
                                             input logic [63:0] x, input logic [63:0] y);
    logic [127:0] sx;
    logic [127:0] sy;
    logic [127:0] ux;
    logic [127:0] uy;
    logic [127:0] p;
    logic [63:0]  w;
    if (!ref_legal(op, word)) return 64'd0;
    sx = {{64{x[63]}}, x};
    sy = {{64{y[63]}}, y};
    ux = {64'b0, x};
    uy = {64'b0, y};
    if (word) begin
      w = {32'b0, x[31:0]} * {32'b0, y[31:0]};
      return {{32{w[31]}}, w[31:0]};
    end
    case (op)
      3'd0:    begin p = ux * uy; return p[63:0]; end
      3'd1:    p = sx * sy;
      3'd2:    p = sx * uy;
      default: p = ux * uy;
    endcase
    return p[127:64];
  endfunction

  function automatic bit ref_hit(input logic [2:0] op, input logic word,
                                 input logic [63:0] x, input logic [63:0] y);
    return cm_valid && !word && ref_legal(op, word) && x == cm_rs1 && y == cm_rs2 &&
           (op == 3'd0 || ref_cls(op) == cm_cls);
  endfunction

  // ---------------- one request/response transaction ----------------
  task automatic do_req(input logic [2:0] op, input logic word, input logic [63:0] rs1,
                        input logic [63:0] rs2, input logic [63:0] exp_data, input bit exp_start,
                        input int stall, input string name);
    logic [TAG_W-1:0] tag;
    logic [63:0]      d0;
    logic [63:0]      exp_a;
    int               s0;
    int               acc_cyc;
    int               n;
    bit               stable;
    tag       = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
    req_op    = op;
    req_word  = word;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_tag   = tag;
    req_valid = 1'b1;
    @(negedge clk);
    check({name, " req_ready"}, req_ready, 1);
    s0 = starts;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_cyc   = cyc;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!resp_valid) begin
      check({name, " resp_valid timeout"}, 0, 1);
    end else begin
      check({name, " data"}, resp_data, exp_data);
      check({name, " tag"}, resp_tag, tag);
      check({name, " core started"}, (starts != s0), exp_start);
      if (exp_start) begin
        exp_a = word ? {32'b0, rs1[31:0]} : (op == 3'd2 && rs1[63]) ? -rs1 : rs1;
        check({name, " resp latency after mul_ready"}, cyc, ready_cyc + 1);
        check({name, " core a"}, seen_a, exp_a);
        check({name, " core b"}, seen_b, word ? {32'b0, rs2[31:0]} : rs2);
        check({name, " core signed"}, {seen_sa, seen_sb}, (op == 3'd1) ? 2'b11 : 2'b00);
        check({name, " mul_start low in RESP"}, mul_start, 0);
        if (!word) begin
          cm_valid = 1;
          cm_rs1   = rs1;
          cm_rs2   = rs2;
          cm_cls   = ref_cls(op);
        end
      end else begin
        check({name, " resp latency after accept"}, cyc, acc_cyc);
      end
      if (stall > 0) begin
        d0 = resp_data;
        stable = 1;
        repeat (stall) begin
          @(negedge clk);
          if (!resp_valid || resp_data !== d0 || resp_tag !== tag || req_ready !== 1'b0)
            stable = 0;
        end
        check({name, " held under stall"}, stable, 1);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        word;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] exp;
    bit          start;
    int          stall;
  } vec_t;

  vec_t        tbl[11];
  logic [63:0] corners[6];
  logic [63:0] r1;
  logic [63:0] r2;
  logic [2:0]  rop;
  logic        rword;
  bit          saw_resp;

  initial begin
    tbl[0]  = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1, 10};
    tbl[1]  = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0};
    tbl[2]  = '{3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 1, 0};
    tbl[3]  = '{3'd0, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 0, 1};
    tbl[4]  = '{3'd0, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 1, 0};
    tbl[5]  = '{3'd1, 1'b1, 64'd5, 64'd7, 64'd0, 0, 0};
    tbl[6]  = '{3'd4, 1'b0, 64'd5, 64'd7, 64'd0, 0, 2};
    tbl[7]  = '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 1, 0};
    tbl[8]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0};
    tbl[9]  = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0};
    tbl[10] = '{3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0};
    corners = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};

    // Reset state: everything low, including req_ready.
    @(negedge clk);
    check("reset req_ready", req_ready, 0);
    check("reset resp_valid", resp_valid, 0);
    check("reset mul_start", mul_start, 0);
    check("reset busy", busy, 0);
    check("reset resp_data", resp_data, 0);
    check("reset mul_a", mul_a, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-reset req_ready", req_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      do_req(tbl[i].op, tbl[i].word, tbl[i].rs1, tbl[i].rs2, tbl[i].exp, tbl[i].start,
             tbl[i].stall, $sformatf("vec%0d", i));
    end

    // Flush five cycles into a long run: start drops at once, no response.
    force_lat = 20;
    req_op = 3'd1; req_word = 1'b0; req_rs1 = 64'd5; req_rs2 = 64'd9; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("flush: start held during run", mul_start, 1);
    check("flush: busy during run", busy, 1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("flush: mul_start dropped", mul_start, 0);
    check("flush: req_ready low", req_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    saw_resp = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1;
    end
    check("flush: no response", saw_resp, 0);
    check("flush: back to idle", busy, 0);
    check("flush: core aborted once", aborts, 1);
    force_lat = 0;
    @(posedge clk);
    #1;
    do_req(3'd0, 1'b0, 64'd7, 64'd6, 64'd42, !ref_hit(3'd0, 1'b0, 64'd7, 64'd6), 0, "mul 7x6");

    // Randomized traffic with operand reuse so the cache is exercised.
    r1 = 64'd3;
    r2 = 64'd5;
    for (int i = 0; i < 60; i++) begin
      rop   = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      rword = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) != 0) begin
        r1 = ($urandom_range(0, 1) == 0) ? corners[$urandom_range(0, 5)] : {$urandom, $urandom};
        r2 = ($urandom_range(0, 1) == 0) ? corners[$urandom_range(0, 5)] : {$urandom, $urandom};
      end
      do_req(rop, rword, r1, r2, ref_result(rop, rword, r1, r2),
             ref_legal(rop, rword) && !ref_hit(rop, rword, r1, r2),
             int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-run: start drops without a clock, cache invalidated.
    do_req(3'd3, 1'b0, 64'd11, 64'd13, 64'd0, !ref_hit(3'd3, 1'b0, 64'd11, 64'd13), 0, "pre-reset");
    force_lat = 20;
    req_op = 3'd0; req_word = 1'b1; req_rs1 = 64'd3; req_rs2 = 64'd4; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset mid-run: start held", mul_start, 1);
    #1;
    rst = 1'b1;
    #1;
    check("reset mid-run: mul_start", mul_start, 0);
    check("reset mid-run: busy", busy, 0);
    cm_valid = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    force_lat = 0;
    @(posedge clk);
    #1;
    do_req(3'd3, 1'b0, 64'd11, 64'd13, 64'd0, 1, 0, "post-reset cache invalid");

    check("mul_start low between ops", gap_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
